i2s_tx_master: RTL and testbench

Clock-domain-native I2S master transmitter. It takes stereo samples from the effect chain (echo, mixer) over a valid/ready handshake, generates `bclk` and `lrclk` from the single system clock, and serialises the samples MSB-first onto `sdata` toward the codec DAC. A one-entry holding buffer decouples sample production from frame timing. When no sample is ready, the block sends silence and reports an underrun.

---
 rtl/i2s_tx_master.sv | 174 +++++++++++++++++
 tb/tb_i2s_tx_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: derives bclk/lrclk from clk and shifts stereo samples out MSB-first.
// A one-entry holding buffer feeds each frame; an empty buffer at frame load sends silence.
module i2s_tx_master #(
    parameter int unsigned BITSIZE  = 24,
    parameter int unsigned SLOTBITS = 32,
    parameter int unsigned BCLK_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic signed [BITSIZE-1:0] left_in,
    input  logic signed [BITSIZE-1:0] right_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      bclk,
    output logic                      lrclk,
    output logic                      sdata,
    output logic                      frame_start,
    output logic                      underrun
);

    localparam int unsigned FrameBits = 2 * SLOTBITS;
    localparam int unsigned KW        = $clog2(FrameBits);
    localparam int unsigned DW        = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [KW-1:0] KLast   = KW'(FrameBits - 1);
    localparam logic [KW-1:0] LrFirst = KW'(SLOTBITS - 1);
    localparam logic [KW-1:0] LrLast  = KW'(FrameBits - 2);
    localparam logic [DW-1:0] DivLast = DW'(BCLK_DIV - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [KW-1:0]        k_q, k_d, k_next;
    logic                 bclk_q, bclk_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic                 frame_start_q, frame_start_d;
    logic                 underrun_q, underrun_d;
    logic [FrameBits-1:0] shift_q, shift_d, shift_next;
    logic                 hold_full_q, hold_full_d;
    logic                 in_ready_q, in_ready_d;
    logic [BITSIZE-1:0]   hold_l_q, hold_l_d;
    logic [BITSIZE-1:0]   hold_r_q, hold_r_d;
    logic [SLOTBITS-1:0]  left_slot, right_slot;
    logic                 load;
    logic                 accept;

    // Samples sit left-justified in their slot; the remaining bits are zero padding.
    assign left_slot  = SLOTBITS'(hold_l_q) << (SLOTBITS - BITSIZE);
    assign right_slot = SLOTBITS'(hold_r_q) << (SLOTBITS - BITSIZE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            div_q         <= '0;
            k_q           <= KLast;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            shift_q       <= '0;
            hold_full_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            k_q           <= k_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            shift_q       <= shift_d;
            hold_full_q   <= hold_full_d;
            in_ready_q    <= in_ready_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        k_d           = k_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        shift_d       = shift_q;
        shift_next    = '0;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        load          = 1'b0;
        k_next        = (k_q == KLast) ? '0 : k_q + KW'(1);

        unique case (state_q)
            StIdle: begin
                div_d   = '0;
                bclk_d  = 1'b0;
                k_d     = KLast;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
                shift_d = '0;
                if (enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!enable) begin
                    // Stopping truncates the frame and drops whatever is left in the shifter.
                    state_d = StIdle;
                    div_d   = '0;
                    bclk_d  = 1'b0;
                    k_d     = KLast;
                    lrclk_d = 1'b0;
                    sdata_d = 1'b0;
                    shift_d = '0;
                end else if (div_q == DivLast) begin
                    div_d  = '0;
                    bclk_d = !bclk_q;
                    if (bclk_q) begin
                        k_d     = k_next;
                        lrclk_d = (k_next >= LrFirst) && (k_next <= LrLast);
                        if (k_next == '0) begin
                            load          = 1'b1;
                            frame_start_d = 1'b1;
                            if (hold_full_q) begin
                                shift_next = {left_slot, right_slot};
                            end else begin
                                underrun_d = 1'b1;
                            end
                        end else begin
                            shift_next = shift_q << 1;
                        end
                        shift_d = shift_next;
                        sdata_d = shift_next[FrameBits-1];
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A load only ever empties a full buffer; accept is blocked while full, so they never collide.
    always_comb begin
        accept      = in_valid && in_ready_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = left_in;
            hold_r_d    = right_in;
        end
        in_ready_d = !hold_full_d;
    end

    assign in_ready    = in_ready_q;
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: time-based frame model checked every cycle, plus literal pins.
module tb_i2s_tx_master;

    localparam int B = 24;
    localparam int S = 32;
    localparam int D = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic signed [B-1:0] left_in = '0;
    logic signed [B-1:0] right_in = '0;
    logic                in_valid = 1'b0;
    logic                in_ready, bclk, lrclk, sdata, frame_start, underrun;

    int errs = 0;
    int checks = 0;

    i2s_tx_master #(.BITSIZE(B), .SLOTBITS(S), .BCLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .left_in(left_in), .right_in(right_in),
        .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = !clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: outputs derived from the number of clocks spent running since enable.
    bit          m_run = 0, m_full = 0, acc;
    int          m_n = 0, f, k;
    logic [B-1:0] m_l, m_r, cur_l = '0, cur_r = '0;
    logic        e_bclk = 0, e_lr = 0, e_sd = 0, e_fs = 0, e_ur = 0, e_rdy = 1;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 0; m_n = 0; m_full = 0;
            e_bclk = 0; e_lr = 0; e_sd = 0; e_fs = 0; e_ur = 0; e_rdy = 1;
        end else begin
            acc = in_valid && e_rdy;
            if (enable) begin
                if (m_run) m_n++;
                else begin m_run = 1; m_n = 0; end
            end else m_run = 0;
            e_fs = 0; e_ur = 0;
            if (m_run) begin
                f = m_n / (2 * D);
                k = (f + 2 * S - 1) % (2 * S);
                e_bclk = ((m_n / D) % 2) == 1;
                if (m_n > 0 && m_n % (2 * D) == 0 && k == 0) begin
                    e_fs = 1;
                    if (m_full) begin cur_l = m_l; cur_r = m_r; m_full = 0; end
                    else begin cur_l = '0; cur_r = '0; e_ur = 1; end
                end
                e_lr = (k >= S - 1) && (k <= 2 * S - 2);
                if (k < B) e_sd = cur_l[B-1-k];
                else if (k >= S && k < S + B) e_sd = cur_r[B-1-(k-S)];
                else e_sd = 0;
            end else begin
                e_bclk = 0; e_lr = 0; e_sd = 0;
            end
            if (acc) begin m_l = left_in; m_r = right_in; m_full = 1; end
            e_rdy = !m_full;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("bclk", 64'(bclk), 64'(e_bclk));
            chk("lrclk", 64'(lrclk), 64'(e_lr));
            chk("sdata", 64'(sdata), 64'(e_sd));
            chk("frame_start", 64'(frame_start), 64'(e_fs));
            chk("underrun", 64'(underrun), 64'(e_ur));
            chk("in_ready", 64'(in_ready), 64'(e_rdy));
        end
    end

    task automatic wait_fs(input int bound, output int n, output bit ok);
        ok = 0; n = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (frame_start) begin n = i; ok = 1; break; end
        end
        if (!ok) chk("frame_start_timeout", 64'd0, 64'd1);
    endtask

    // Waits for a frame start, then samples sdata/lrclk at the next 64 bclk rises (k=0 at MSB).
    task automatic collect(output logic [63:0] sv, output logic [63:0] lv);
        int n, nr;
        bit ok, prev;
        sv = '0; lv = '0; nr = 0;
        wait_fs(600, n, ok);
        prev = bclk;
        for (int i = 0; i < 64 * 2 * D + 8 && nr < 64; i++) begin
            @(negedge clk);
            if (bclk && !prev) begin
                sv = {sv[62:0], sdata};
                lv = {lv[62:0], lrclk};
                nr++;
            end
            prev = bclk;
        end
        if (nr < 64) chk("collect_timeout", 64'(nr), 64'd64);
    endtask

    logic [63:0] sv, lv;
    int n, cnt, idx, nr, last, nf, fsn, urn;
    int acc_at[3];
    int fs_at[4];
    bit ok, pend, prev;
    logic [B-1:0] pl[3] = '{24'h111111, 24'h222222, 24'h333333};
    logic [B-1:0] pr[3] = '{24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_outs", 64'({bclk, lrclk, sdata, frame_start, underrun}), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_outs", 64'({bclk, lrclk, sdata}), 64'd0);

        // Underrun: empty buffer at the first load, silence for the frame.
        enable = 1'b1;
        wait_fs(20, n, ok);
        chk("first_load_cycle", 64'(n), 64'd5);
        chk("first_underrun", 64'(underrun), 64'd1);
        cnt = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (sdata) cnt++;
        end
        chk("underrun_silence", 64'(cnt), 64'd0);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // Single sample.
        left_in = 24'hA5F00F; right_in = 24'h123456; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("held_not_ready", 64'(in_ready), 64'd0);
        enable = 1'b1;
        collect(sv, lv);
        chk("single_sdata", sv, {24'hA5F00F, 8'h00, 24'h123456, 8'h00});
        chk("single_lrclk", lv, 64'h0000_0001_FFFF_FFFE);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // Backpressure: three pairs offered back to back.
        idx = 0; pend = 0; fsn = 0; urn = 0;
        for (int c = 1; c <= 1200 && fsn < 4; c++) begin
            @(negedge clk);
            if (pend) idx++;
            if (frame_start) begin
                fsn++;
                if (fsn <= 4) fs_at[fsn-1] = c;
                if (underrun && fsn <= 3) urn++;
            end
            if (idx >= 1) enable = 1'b1;
            if (idx < 3) begin
                left_in = pl[idx]; right_in = pr[idx]; in_valid = 1'b1;
            end else in_valid = 1'b0;
            pend = in_valid && in_ready;
            if (pend) acc_at[idx] = c + 1;
        end
        in_valid = 1'b0;
        chk("bp_frames", 64'(fsn), 64'd4);
        chk("bp_no_underrun", 64'(urn), 64'd0);
        chk("bp_accept2_after_load", 64'(acc_at[1] - fs_at[0]), 64'd1);
        chk("bp_accept3_spacing", 64'(acc_at[2] - acc_at[1]), 64'd256);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // Enable drop mid-frame keeps the holding sample intact.
        left_in = 24'hFFFFFF; right_in = 24'h0F0F0F; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        enable = 1'b1;
        wait_fs(20, n, ok);
        left_in = 24'h800001; right_in = 24'h7FFFFE; in_valid = 1'b1;
        for (int j = 1; j <= 42; j++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("drop_pre_state", 64'({bclk, sdata}), 64'b11);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_outs_zero", 64'({bclk, lrclk, sdata}), 64'd0);
        repeat (4) @(negedge clk);
        chk("drop_held", 64'(in_ready), 64'd0);
        enable = 1'b1;
        collect(sv, lv);
        chk("retained_sdata", sv, {24'h800001, 8'h00, 24'h7FFFFE, 8'h00});

        // Rates.
        prev = bclk; last = -1; nr = 0;
        for (int i = 0; i < 40 && nr < 5; i++) begin
            @(negedge clk);
            if (bclk && !prev) begin
                if (last >= 0) chk("bclk_period", 64'(i - last), 64'd4);
                last = i; nr++;
            end
            prev = bclk;
        end
        if (nr < 5) chk("bclk_rise_timeout", 64'(nr), 64'd5);
        last = -1; nf = 0;
        for (int i = 0; i < 3000 && nf < 11; i++) begin
            @(negedge clk);
            if (frame_start) begin
                if (last >= 0) chk("frame_spacing", 64'(i - last), 64'd256);
                last = i; nf++;
            end
        end
        if (nf < 11) chk("frame_timeout", 64'(nf), 64'd11);

        // Asynchronous reset mid-frame.
        repeat (37) @(negedge clk);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_rst_outs", 64'({bclk, lrclk, sdata, frame_start, underrun}), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", 64'({bclk, lrclk, sdata}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
